// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register select codes, register-transfer op codes,
// sequencer state encoding and select-code helpers.
package cpu_pkg;

  localparam logic [7:0] AL = 8'h01;
  localparam logic [7:0] BL = 8'h02;
  localparam logic [7:0] CL = 8'h04;
  localparam logic [7:0] DL = 8'h08;

  typedef enum logic [1:0] {
    OP_MOV  = 2'b00,
    OP_LDI  = 2'b01,
    OP_XCHG = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_CAP_A,
    ST_RD_B,
    ST_CAP_B,
    ST_WR_1,
    ST_WR_2,
    ST_DONE
  } state_e;

  function automatic logic is_valid_sel(input logic [7:0] sel);
    return (sel == AL) || (sel == BL) || (sel == CL) || (sel == DL);
  endfunction

  // Only MOV and XCHG read a source register; LDI/CLR ignore cmd_src.
  function automatic logic uses_src(input op_e op);
    return (op == OP_MOV) || (op == OP_XCHG);
  endfunction

endpackage

// File: rtl/reg_xfer_seq.sv
// Register-transfer sequencer: runs MOV/LDI/XCHG/CLR as multi-cycle read and
// write sequences on the register file port, one command at a time.
module reg_xfer_seq
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [7:0]        cmd_dst,
  input  logic [7:0]        cmd_src,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              reg_r,
  output logic [7:0]        reg_r_select,
  input  logic [DATA_W-1:0] reg_r_line,
  output logic              reg_w,
  output logic [7:0]        reg_w_select,
  output logic [DATA_W-1:0] reg_w_line,
  output logic              done,
  output logic              err
);

  state_e            state, state_nxt;
  op_e               op_q;
  logic [7:0]        dst_q, src_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] tmp_a, tmp_b;
  logic              err_q;

  op_e  cmd_op_e;
  logic cmd_ok;
  logic accept;

  assign cmd_op_e  = op_e'(cmd_op);
  assign cmd_ready = (state == ST_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_ok    = is_valid_sel(cmd_dst) &&
                     (!uses_src(cmd_op_e) || is_valid_sel(cmd_src));

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!cmd_ok)             state_nxt = ST_DONE;
          else if (uses_src(cmd_op_e)) state_nxt = ST_RD_A;
          else                     state_nxt = ST_WR_1;
        end
      end
      ST_RD_A:  state_nxt = ST_CAP_A;
      ST_CAP_A: state_nxt = (op_q == OP_XCHG) ? ST_RD_B : ST_WR_1;
      ST_RD_B:  state_nxt = ST_CAP_B;
      ST_CAP_B: state_nxt = ST_WR_1;
      ST_WR_1:  state_nxt = (op_q == OP_XCHG) ? ST_WR_2 : ST_DONE;
      ST_WR_2:  state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Command registers: the requester may change cmd_* freely after accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= OP_MOV;
      dst_q <= '0;
      src_q <= '0;
      imm_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      op_q  <= cmd_op_e;
      dst_q <= cmd_dst;
      src_q <= cmd_src;
      imm_q <= cmd_imm;
      err_q <= !cmd_ok;
    end
  end

  // Capture at the end of CAP_x so both combinational and registered
  // reg_file read paths have settled by then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmp_a <= '0;
      tmp_b <= '0;
    end else begin
      if (state == ST_CAP_A) tmp_a <= reg_r_line;
      if (state == ST_CAP_B) tmp_b <= reg_r_line;
    end
  end

  // NOTE: every output gets a default before the case, so no path through
  // this block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    reg_r        = 1'b0;
    reg_r_select = '0;
    reg_w        = 1'b0;
    reg_w_select = '0;
    reg_w_line   = '0;
    done         = 1'b0;
    err          = 1'b0;
    case (state)
      ST_RD_A, ST_CAP_A: begin
        reg_r        = 1'b1;
        reg_r_select = src_q;
      end
      ST_RD_B, ST_CAP_B: begin
        reg_r        = 1'b1;
        reg_r_select = dst_q;
      end
      ST_WR_1: begin
        reg_w        = 1'b1;
        reg_w_select = dst_q;
        case (op_q)
          OP_MOV, OP_XCHG: reg_w_line = tmp_a;
          OP_LDI:          reg_w_line = imm_q;
          default:         reg_w_line = '0;
        endcase
      end
      ST_WR_2: begin
        reg_w        = 1'b1;
        reg_w_select = src_q;
        reg_w_line   = tmp_b;
      end
      ST_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

endmodule
